// File: rtl/ofmap_collector_pkg.sv
// Shared types and params-field layout for the ofmap collector.
// Optional checksum output is enabled with macro OFMAP_COLLECTOR_CHECKSUM_EN.
package ofmap_collector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // params_dat is packed {OY1, OC1, OY0}; a field's lsb is its index times the field width
  localparam int OY1_FIELD = 2;
  localparam int OC1_FIELD = 1;
  localparam int OY0_FIELD = 0;

  function automatic int field_lsb(input int field, input int wid);
    return field * wid;
  endfunction

  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/ofmap_collector_if.sv
// Params, ofmap stream and output-memory write bundle for the ofmap collector.
interface ofmap_collector_if #(
  parameter int PARAM_WID  = 16,
  parameter int ADDR_WIDTH = 32
);

  logic [3*PARAM_WID-1:0] params_dat;
  logic                   params_vld;
  logic                   params_rdy;
  logic [31:0]            ofmap_dat;
  logic                   ofmap_vld;
  logic                   ofmap_rdy;
  logic                   mem_wen;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [31:0]            mem_wdata;
  logic                   done;

  modport master (
    output params_dat, params_vld, ofmap_dat, ofmap_vld,
    input  params_rdy, ofmap_rdy, mem_wen, mem_waddr, mem_wdata, done
  );

  modport slave (
    input  params_dat, params_vld, ofmap_dat, ofmap_vld,
    output params_rdy, ofmap_rdy, mem_wen, mem_waddr, mem_wdata, done
  );

endinterface

// File: rtl/ofmap_nested_counter.sv
// Six cascaded wrapping counters walking oy1, ox1, oc1, oy0, ox0, oc0 (outermost first).
module ofmap_nested_counter
  import ofmap_collector_pkg::*;
#(
  parameter int OC0       = 4,
  parameter int PARAM_WID = 16,
  localparam int OC0_W    = cnt_width(OC0)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [PARAM_WID-1:0] oy1_bound,
  input  logic [PARAM_WID-1:0] oc1_bound,
  input  logic [PARAM_WID-1:0] oy0_bound,
  output logic [PARAM_WID-1:0] oy1,
  output logic [PARAM_WID-1:0] ox1,
  output logic [PARAM_WID-1:0] oc1,
  output logic [PARAM_WID-1:0] oy0,
  output logic [PARAM_WID-1:0] ox0,
  output logic [OC0_W-1:0]     oc0,
  output logic                 all_wrap
);

  logic last_oc0, last_ox0, last_oy0, last_oc1, last_ox1, last_oy1;
  logic wrap_oc0, wrap_ox0, wrap_oy0, wrap_oc1, wrap_ox1;

  assign last_oc0 = (oc0 == OC0_W'(OC0 - 1));
  assign last_ox0 = (ox0 == oy0_bound - PARAM_WID'(1));
  assign last_oy0 = (oy0 == oy0_bound - PARAM_WID'(1));
  assign last_oc1 = (oc1 == oc1_bound - PARAM_WID'(1));
  assign last_ox1 = (ox1 == oy1_bound - PARAM_WID'(1));
  assign last_oy1 = (oy1 == oy1_bound - PARAM_WID'(1));

  // Each level carries into the next outer one only when it and all inner levels wrap
  assign wrap_oc0 = en && last_oc0;
  assign wrap_ox0 = wrap_oc0 && last_ox0;
  assign wrap_oy0 = wrap_ox0 && last_oy0;
  assign wrap_oc1 = wrap_oy0 && last_oc1;
  assign wrap_ox1 = wrap_oc1 && last_ox1;
  assign all_wrap = wrap_ox1 && last_oy1;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      oy1 <= '0;
      ox1 <= '0;
      oc1 <= '0;
      oy0 <= '0;
      ox0 <= '0;
      oc0 <= '0;
    end else begin
      if (en)       oc0 <= last_oc0 ? '0 : oc0 + OC0_W'(1);
      if (wrap_oc0) ox0 <= last_ox0 ? '0 : ox0 + PARAM_WID'(1);
      if (wrap_ox0) oy0 <= last_oy0 ? '0 : oy0 + PARAM_WID'(1);
      if (wrap_oy0) oc1 <= last_oc1 ? '0 : oc1 + PARAM_WID'(1);
      if (wrap_oc1) ox1 <= last_ox1 ? '0 : ox1 + PARAM_WID'(1);
      if (wrap_ox1) oy1 <= last_oy1 ? '0 : oy1 + PARAM_WID'(1);
    end
  end

endmodule

// File: rtl/ofmap_collector.sv
// Collects the tiled accelerator ofmap stream into an oc-major output memory image.
// Define OFMAP_COLLECTOR_CHECKSUM_EN to add a per-layer wrapping checksum output.
module ofmap_collector
  import ofmap_collector_pkg::*;
#(
  parameter int OC0        = 4,
  parameter int PARAM_WID  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ofmap_collector_if.slave  bus
`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int OC0_W   = cnt_width(OC0);
  localparam int OY1_LSB = field_lsb(OY1_FIELD, PARAM_WID);
  localparam int OC1_LSB = field_lsb(OC1_FIELD, PARAM_WID);
  localparam int OY0_LSB = field_lsb(OY0_FIELD, PARAM_WID);

  state_t                state;
  logic [PARAM_WID-1:0]  oy1_q, oc1_q, oy0_q;
  logic [PARAM_WID-1:0]  p_oy1, p_oc1, p_oy0;
  logic                  params_acc, beat, all_wrap;
  logic [PARAM_WID-1:0]  oy1_c, ox1_c, oc1_c, oy0_c, ox0_c;
  logic [OC0_W-1:0]      oc0_c;
  logic [ADDR_WIDTH-1:0] oy, ox, oc, oy_total, waddr;

  assign p_oy1 = bus.params_dat[OY1_LSB +: PARAM_WID];
  assign p_oc1 = bus.params_dat[OC1_LSB +: PARAM_WID];
  assign p_oy0 = bus.params_dat[OY0_LSB +: PARAM_WID];

  assign params_acc = bus.params_vld && bus.params_rdy && (state == IDLE);
  assign beat       = bus.ofmap_vld && bus.ofmap_rdy;

  ofmap_nested_counter #(
    .OC0       (OC0),
    .PARAM_WID (PARAM_WID)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (params_acc),
    .en        (beat),
    .oy1_bound (oy1_q),
    .oc1_bound (oc1_q),
    .oy0_bound (oy0_q),
    .oy1       (oy1_c),
    .ox1       (ox1_c),
    .oc1       (oc1_c),
    .oy0       (oy0_c),
    .ox0       (ox0_c),
    .oc0       (oc0_c),
    .all_wrap  (all_wrap)
  );

  // Square tiles: the x extent reuses the y tile sizes
  assign oy       = ADDR_WIDTH'(oy1_c) * ADDR_WIDTH'(oy0_q) + ADDR_WIDTH'(oy0_c);
  assign ox       = ADDR_WIDTH'(ox1_c) * ADDR_WIDTH'(oy0_q) + ADDR_WIDTH'(ox0_c);
  assign oc       = ADDR_WIDTH'(oc1_c) * ADDR_WIDTH'(OC0) + ADDR_WIDTH'(oc0_c);
  assign oy_total = ADDR_WIDTH'(oy1_q) * ADDR_WIDTH'(oy0_q);
  assign waddr    = ((oc * oy_total) + oy) * oy_total + ox;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      oy1_q          <= '0;
      oc1_q          <= '0;
      oy0_q          <= '0;
      bus.params_rdy <= 1'b0;
      bus.ofmap_rdy  <= 1'b0;
      bus.done       <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.mem_wen <= beat;
      if (beat) begin
        bus.mem_waddr <= waddr;
        bus.mem_wdata <= bus.ofmap_dat;
      end

      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (params_acc) begin
            oy1_q          <= p_oy1;
            oc1_q          <= p_oc1;
            oy0_q          <= p_oy0;
            bus.params_rdy <= 1'b0;
            // A zero-sized layer has nothing to collect, so finish immediately
            if (p_oy1 == '0 || p_oc1 == '0 || p_oy0 == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state         <= RUN;
              bus.ofmap_rdy <= 1'b1;
            end
          end else begin
            bus.params_rdy <= 1'b1;
          end
        end
        RUN: begin
          if (all_wrap) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.ofmap_rdy <= 1'b0;
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.done       <= 1'b0;
          bus.params_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || params_acc) begin
      checksum <= '0;
    end else if (beat) begin
      checksum <= checksum + bus.ofmap_dat;
    end
  end
`endif

endmodule

// File: tb/tb_ofmap_collector.sv
// Directed self-checking bench for ofmap_collector: reset, small and tiled layers,
// zero-sized layer, mid-layer reset and (with OFMAP_COLLECTOR_CHECKSUM_EN) the checksum.
`timescale 1ns/1ps
module tb_ofmap_collector;

  localparam int OC0        = 4;
  localparam int PARAM_WID  = 16;
  localparam int ADDR_WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  ofmap_collector_if #(.PARAM_WID(PARAM_WID), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  ofmap_collector #(
    .OC0        (OC0),
    .PARAM_WID  (PARAM_WID),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Write/done monitor samples on the falling edge, away from the active edge
  int                    wr_cnt, done_cnt, done_wen_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q[$];
  logic [31:0]           wr_data_q[$];
  logic [31:0]           done_csum;
  logic [31:0]           stim_data[$];

  always @(negedge clk) begin
    if (bus.mem_wen === 1'b1) begin
      wr_cnt++;
      wr_addr_q.push_back(bus.mem_waddr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (bus.mem_wen === 1'b1) done_wen_cnt++;
`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
      done_csum = checksum;
`else
      done_csum = '0;
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    wr_cnt       = 0;
    done_cnt     = 0;
    done_wen_cnt = 0;
    done_csum    = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_params(input int oy1, input int oc1, input int oy0);
    int waited;
    waited         = 0;
    bus.params_dat = {PARAM_WID'(oy1), PARAM_WID'(oc1), PARAM_WID'(oy0)};
    bus.params_vld = 1'b1;
    while (bus.params_rdy !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (bus.params_rdy !== 1'b1) checkOutput("params_timeout", 64'd0, 64'd1);
    step();
    bus.params_vld = 1'b0;
  endtask

  // Drives stim_data as ofmap beats, optionally with random idle gaps, stopping after max_beats
  task automatic applyStimulus(input int gap_pct, input int max_beats);
    for (int i = 0; i < stim_data.size() && i < max_beats; i++) begin
      int waited;
      waited = 0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.ofmap_vld = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      bus.ofmap_vld = 1'b1;
      bus.ofmap_dat = stim_data[i];
      while (bus.ofmap_rdy !== 1'b1 && waited < 50) begin
        step();
        waited++;
      end
      if (bus.ofmap_rdy !== 1'b1) begin
        checkOutput("beat_timeout", 64'd0, 64'd1);
        break;
      end
      step();
    end
    bus.ofmap_vld = 1'b0;
  endtask

  // Expected address of beat idx from a mixed-radix decomposition of the stream order
  function automatic logic [ADDR_WIDTH-1:0] model_addr(input int idx, input int oy1b, input int oc1b, input int oy0b);
    int r, c_oc0, c_ox0, c_oy0, c_oc1, c_ox1, c_oy1, oy_t;
    c_oc0 = idx % OC0;   r = idx / OC0;
    c_ox0 = r % oy0b;    r = r / oy0b;
    c_oy0 = r % oy0b;    r = r / oy0b;
    c_oc1 = r % oc1b;    r = r / oc1b;
    c_ox1 = r % oy1b;    r = r / oy1b;
    c_oy1 = r;
    oy_t  = oy1b * oy0b;
    return ADDR_WIDTH'(((c_oc1 * OC0 + c_oc0) * oy_t + c_oy1 * oy0b + c_oy0) * oy_t + c_ox1 * oy0b + c_ox0);
  endfunction

  task automatic check_layer(input string tag, input int oy1b, input int oc1b, input int oy0b);
    int n;
    n = stim_data.size();
    checkOutput({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(n));
    checkOutput({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, "_done_with_last_wr"}, 64'(done_wen_cnt), 64'd1);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(model_addr(i, oy1b, oc1b, oy0b)));
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(stim_data[i]));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] seen;
    int          uniq;
    logic        rdy_seen;

    rst_n          = 1'b0;
    bus.params_vld = 1'b1;
    bus.ofmap_vld  = 1'b1;
    bus.params_dat = {16'd1, 16'd1, 16'd1};
    bus.ofmap_dat  = 32'hDEAD_BEEF;
    clear_monitor();

    // Reset held with both valids high
    repeat (3) step();
    checkOutput("rst_params_rdy", 64'(bus.params_rdy), 64'd0);
    checkOutput("rst_ofmap_rdy", 64'(bus.ofmap_rdy), 64'd0);
    checkOutput("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
    checkOutput("rst_mem_waddr", 64'(bus.mem_waddr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    rst_n          = 1'b1;
    bus.params_vld = 1'b0;
    bus.ofmap_vld  = 1'b0;
    step();
    checkOutput("rst_release_params_rdy", 64'(bus.params_rdy), 64'd1);
    checkOutput("rst_release_ofmap_rdy", 64'(bus.ofmap_rdy), 64'd0);
    clear_monitor();

    // Layer A: {1,1,1}, data 1..4 -> addresses 0..3
    $display("[TB] layer A {1,1,1}");
    stim_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_params(1, 1, 1);
    applyStimulus(0, 1000);
    checkOutput("a_rdy_drop", 64'(bus.ofmap_rdy), 64'd0);
    checkOutput("a_done_now", 64'(bus.done), 64'd1);
    checkOutput("a_last_waddr", 64'(bus.mem_waddr), 64'd3);
    checkOutput("a_last_wdata", 64'(bus.mem_wdata), 64'd4);
    step();
    checkOutput("a_done_one_cycle", 64'(bus.done), 64'd0);
    checkOutput("a_idle_params_rdy", 64'(bus.params_rdy), 64'd1);
    step();
    check_layer("a", 1, 1, 1);
`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
    checkOutput("a_checksum", 64'(done_csum), 64'd10);
`endif

    // Layer B: {2,1,2}, 64 beats with random gaps
    $display("[TB] layer B {2,1,2}");
    clear_monitor();
    stim_data.delete();
    for (int i = 0; i < 64; i++) stim_data.push_back(32'(100 + i));
    send_params(2, 1, 2);
    applyStimulus(30, 1000);
    repeat (3) step();
    check_layer("b", 2, 1, 2);
    checkOutput("b_beat4_addr", (wr_addr_q.size() > 4) ? 64'(wr_addr_q[4]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    seen = '0;
    uniq = 0;
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] < 64 && !seen[wr_addr_q[i][5:0]]) begin
        seen[wr_addr_q[i][5:0]] = 1'b1;
        uniq++;
      end
    end
    checkOutput("b_addr_unique", 64'(uniq), 64'd64);

    // Layer C: OC1=0 finishes immediately and ignores ofmap_vld
    $display("[TB] layer C zero OC1");
    clear_monitor();
    send_params(1, 0, 1);
    checkOutput("c_done_after_accept", 64'(bus.done), 64'd1);
    bus.ofmap_vld = 1'b1;
    bus.ofmap_dat = 32'h1234_5678;
    rdy_seen      = bus.ofmap_rdy;
    repeat (4) begin
      step();
      rdy_seen = rdy_seen | bus.ofmap_rdy;
    end
    bus.ofmap_vld = 1'b0;
    checkOutput("c_ofmap_rdy_low", 64'(rdy_seen), 64'd0);
    checkOutput("c_no_writes", 64'(wr_cnt), 64'd0);
    checkOutput("c_done_cnt", 64'(done_cnt), 64'd1);

    // Layer D: reset after 10 of 64 beats, then a clean {1,1,1} layer
    $display("[TB] layer D mid-layer reset");
    clear_monitor();
    stim_data.delete();
    for (int i = 0; i < 64; i++) stim_data.push_back(32'(200 + i));
    send_params(2, 1, 2);
    applyStimulus(0, 10);
    rst_n         = 1'b0;
    bus.ofmap_vld = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    bus.ofmap_vld = 1'b0;
    checkOutput("d_writes_before_reset", 64'(wr_cnt), 64'd10);
    checkOutput("d_no_done_on_abort", 64'(done_cnt), 64'd0);
    clear_monitor();
    stim_data = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_params(1, 1, 1);
    applyStimulus(0, 1000);
    repeat (2) step();
    check_layer("d", 1, 1, 1);
`ifdef OFMAP_COLLECTOR_CHECKSUM_EN
    checkOutput("d_checksum", 64'(done_csum), 64'd26);

    // Layer E: checksum wraps modulo 2^32
    $display("[TB] layer E checksum wrap");
    clear_monitor();
    stim_data = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1};
    send_params(1, 1, 1);
    applyStimulus(0, 1000);
    repeat (2) step();
    check_layer("e", 1, 1, 1);
    checkOutput("e_checksum_wrap", 64'(done_csum), 64'd0);
    checkOutput("e_checksum_stable", 64'(checksum), 64'd0);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
